// File: rtl/pu_riscv_biu_pkg.sv
// Shared definitions for the PU RISC-V BIU arbiter.
//  - biu_type_t  : burst type encoding seen on every BIU port
//  - arb_state_t : arbiter FSM states
//  - biu_beats() : number of data beats implied by a burst type
package pu_riscv_biu_pkg;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } biu_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // Undefined-length INCR is treated as a single beat.
  function automatic logic [4:0] biu_beats(input logic [2:0] btype);
    logic [4:0] n;
    case (biu_type_t'(btype))
      SINGLE, INCR:   n = 5'd1;
      WRAP4, INCR4:   n = 5'd4;
      WRAP8, INCR8:   n = 5'd8;
      default:        n = 5'd16;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pu_riscv_biu_beat_cnt.sv
// Burst beat counter for the BIU arbiter.
// Ports:
//  clk_i       clock
//  rst_i       synchronous active-high reset (clears the count)
//  load_i      load load_val_i (has priority over dec_i)
//  load_val_i  beats still outstanding
//  dec_i       one beat acknowledged
//  cnt_o       beats still outstanding
//  last_o      exactly one beat left
module pu_riscv_biu_beat_cnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [4:0] load_val_i,
  input  logic       dec_i,
  output logic [4:0] cnt_o,
  output logic       last_o
);

  logic [4:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 5'd0)) begin
      // saturate at zero: stray acks never wrap the count
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 5'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == 5'd1);

endmodule

// File: rtl/pu_riscv_biu_arbiter.sv
// Two-master BIU arbiter: instruction (ibiu_*) and data (dbiu_*) masters share
// one downstream BIU port (biu_*). Arbitration is per transaction; the winner's
// request is forwarded combinationally, burst beats are counted and handshakes
// are routed back to the owner only.
// Ports:
//  HCLK, HRESET               clock, synchronous active-high reset
//  ibiu_* / dbiu_* inputs     request bundles (stb, adri, size, type, we, lock, prot, d)
//  ibiu_* / dbiu_* outputs    stb_ack, d_ack, ack, err (owner only), adro, q (broadcast)
//  biu_* outputs              merged request bundle
//  biu_* inputs               downstream stb_ack, d_ack, ack, err, adro, q
module pu_riscv_biu_arbiter #(
  parameter int XLEN  = 32,
  parameter int PLEN  = 32,
  parameter int DPRIO = 1
) (
  input  logic            HCLK,
  input  logic            HRESET,
  // instruction master
  input  logic            ibiu_stb,
  input  logic [PLEN-1:0] ibiu_adri,
  input  logic [2:0]      ibiu_size,
  input  logic [2:0]      ibiu_type,
  input  logic            ibiu_we,
  input  logic            ibiu_lock,
  input  logic [2:0]      ibiu_prot,
  input  logic [XLEN-1:0] ibiu_d,
  output logic            ibiu_stb_ack,
  output logic            ibiu_d_ack,
  output logic            ibiu_ack,
  output logic            ibiu_err,
  output logic [PLEN-1:0] ibiu_adro,
  output logic [XLEN-1:0] ibiu_q,
  // data master
  input  logic            dbiu_stb,
  input  logic [PLEN-1:0] dbiu_adri,
  input  logic [2:0]      dbiu_size,
  input  logic [2:0]      dbiu_type,
  input  logic            dbiu_we,
  input  logic            dbiu_lock,
  input  logic [2:0]      dbiu_prot,
  input  logic [XLEN-1:0] dbiu_d,
  output logic            dbiu_stb_ack,
  output logic            dbiu_d_ack,
  output logic            dbiu_ack,
  output logic            dbiu_err,
  output logic [PLEN-1:0] dbiu_adro,
  output logic [XLEN-1:0] dbiu_q,
  // downstream port
  output logic            biu_stb,
  output logic [PLEN-1:0] biu_adri,
  output logic [2:0]      biu_size,
  output logic [2:0]      biu_type,
  output logic            biu_we,
  output logic            biu_lock,
  output logic [2:0]      biu_prot,
  output logic [XLEN-1:0] biu_d,
  input  logic            biu_stb_ack,
  input  logic            biu_d_ack,
  input  logic            biu_ack,
  input  logic            biu_err,
  input  logic [PLEN-1:0] biu_adro,
  input  logic [XLEN-1:0] biu_q
);

  import pu_riscv_biu_pkg::*;

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;   // 0 = instr, 1 = data
  logic       last_q, last_d;     // owner of the last accepted address phase
  logic       hold_q, hold_d;     // bus locked to owner_q
  logic       hold_eff;

  logic            own_stb, own_lock, own_we;
  logic [PLEN-1:0] own_adri;
  logic [2:0]      own_size, own_type, own_prot;
  logic [XLEN-1:0] own_d;
  logic [4:0]      own_beats;

  logic       cnt_load, cnt_dec, cnt_last;
  logic [4:0] cnt_load_val, cnt_val;
  logic       active;

  // Owner request mux
  assign own_stb   = owner_q ? dbiu_stb  : ibiu_stb;
  assign own_adri  = owner_q ? dbiu_adri : ibiu_adri;
  assign own_size  = owner_q ? dbiu_size : ibiu_size;
  assign own_type  = owner_q ? dbiu_type : ibiu_type;
  assign own_we    = owner_q ? dbiu_we   : ibiu_we;
  assign own_lock  = owner_q ? dbiu_lock : ibiu_lock;
  assign own_prot  = owner_q ? dbiu_prot : ibiu_prot;
  assign own_d     = owner_q ? dbiu_d    : ibiu_d;
  assign own_beats = biu_beats(own_type);

  pu_riscv_biu_beat_cnt u_beat_cnt (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    hold_d       = hold_q;
    hold_eff     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = own_beats;
    cnt_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // In IDLE owner_q is still the previous owner, so own_* is the holder.
        // The hold drops as soon as the holder shows lock=0 with stb=0, and the
        // other side may be granted in that same cycle.
        hold_eff = hold_q && (own_stb || own_lock);
        if (hold_q && !hold_eff) begin
          hold_d = 1'b0;
        end
        if (hold_eff) begin
          if (own_stb) begin
            state_d = ST_ADDR;
          end
        end else if (ibiu_stb && dbiu_stb) begin
          owner_d = (DPRIO != 0) ? 1'b1 : ~last_q;
          state_d = ST_ADDR;
        end else if (ibiu_stb) begin
          owner_d = 1'b0;
          state_d = ST_ADDR;
        end else if (dbiu_stb) begin
          owner_d = 1'b1;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (biu_err) begin
          state_d = ST_IDLE;
        end else if (biu_stb_ack) begin
          last_d = owner_q;
          if (biu_ack) begin
            // zero-wait first beat
            if (own_beats == 5'd1) begin
              state_d = ST_IDLE;
              hold_d  = own_lock;
            end else begin
              cnt_load     = 1'b1;
              cnt_load_val = own_beats - 5'd1;
              state_d      = ST_DATA;
            end
          end else begin
            cnt_load = 1'b1;
            state_d  = ST_DATA;
          end
        end else if (!own_stb) begin
          state_d = ST_IDLE;   // request abandoned before acceptance
        end
      end

      ST_DATA: begin
        if (biu_err) begin
          state_d = ST_IDLE;
        end else if (biu_ack && (cnt_val != 5'd0)) begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_d = ST_IDLE;
            hold_d  = own_lock;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Outputs are quiet in IDLE and while reset is held.
  assign active = (state_q != ST_IDLE) && !HRESET;

  assign biu_stb  = (state_q == ST_ADDR) && !HRESET && own_stb;
  assign biu_adri = active ? own_adri : '0;
  assign biu_size = active ? own_size : '0;
  assign biu_type = active ? own_type : '0;
  assign biu_we   = active && own_we;
  assign biu_lock = active && own_lock;
  assign biu_prot = active ? own_prot : '0;
  assign biu_d    = active ? own_d    : '0;

  assign ibiu_stb_ack = active && !owner_q && biu_stb_ack;
  assign ibiu_d_ack   = active && !owner_q && biu_d_ack;
  assign ibiu_ack     = active && !owner_q && biu_ack;
  assign ibiu_err     = active && !owner_q && biu_err;
  assign dbiu_stb_ack = active &&  owner_q && biu_stb_ack;
  assign dbiu_d_ack   = active &&  owner_q && biu_d_ack;
  assign dbiu_ack     = active &&  owner_q && biu_ack;
  assign dbiu_err     = active &&  owner_q && biu_err;

  assign ibiu_adro = biu_adro;
  assign ibiu_q    = biu_q;
  assign dbiu_adro = biu_adro;
  assign dbiu_q    = biu_q;

endmodule

// File: tb/tb_pu_riscv_biu_arbiter.sv
// Directed + randomized bench for pu_riscv_biu_arbiter. A second instance with
// DPRIO=0 shares the stimulus so the round-robin tie rule can be observed.
module tb_pu_riscv_biu_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        ibiu_stb, dbiu_stb;
  logic [31:0] ibiu_adri, dbiu_adri, ibiu_d, dbiu_d;
  logic [2:0]  ibiu_size, dbiu_size, ibiu_type, dbiu_type, ibiu_prot, dbiu_prot;
  logic        ibiu_we, dbiu_we, ibiu_lock, dbiu_lock;
  logic        ibiu_stb_ack, ibiu_d_ack, ibiu_ack, ibiu_err;
  logic        dbiu_stb_ack, dbiu_d_ack, dbiu_ack, dbiu_err;
  logic [31:0] ibiu_adro, ibiu_q, dbiu_adro, dbiu_q;
  logic        biu_stb, biu_we, biu_lock;
  logic [31:0] biu_adri, biu_d;
  logic [2:0]  biu_size, biu_type, biu_prot;
  logic        biu_stb_ack, biu_d_ack, biu_ack, biu_err;
  logic [31:0] biu_adro, biu_q;
  // round-robin instance outputs
  logic        r_ibiu_stb_ack, r_ibiu_d_ack, r_ibiu_ack, r_ibiu_err;
  logic        r_dbiu_stb_ack, r_dbiu_d_ack, r_dbiu_ack, r_dbiu_err;
  logic [31:0] r_ibiu_adro, r_ibiu_q, r_dbiu_adro, r_dbiu_q;
  logic        r_biu_stb, r_biu_we, r_biu_lock;
  logic [31:0] r_biu_adri, r_biu_d;
  logic [2:0]  r_biu_size, r_biu_type, r_biu_prot;

  int checks = 0;
  int failures = 0;
  int beats_tab [8] = '{1, 1, 4, 4, 8, 8, 16, 16};
  bit model_last = 1'b0;   // side of the last accepted address phase

  always #5 HCLK = ~HCLK;

  pu_riscv_biu_arbiter #(.XLEN(32), .PLEN(32), .DPRIO(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .ibiu_stb(ibiu_stb), .ibiu_adri(ibiu_adri), .ibiu_size(ibiu_size), .ibiu_type(ibiu_type),
    .ibiu_we(ibiu_we), .ibiu_lock(ibiu_lock), .ibiu_prot(ibiu_prot), .ibiu_d(ibiu_d),
    .ibiu_stb_ack(ibiu_stb_ack), .ibiu_d_ack(ibiu_d_ack), .ibiu_ack(ibiu_ack), .ibiu_err(ibiu_err),
    .ibiu_adro(ibiu_adro), .ibiu_q(ibiu_q),
    .dbiu_stb(dbiu_stb), .dbiu_adri(dbiu_adri), .dbiu_size(dbiu_size), .dbiu_type(dbiu_type),
    .dbiu_we(dbiu_we), .dbiu_lock(dbiu_lock), .dbiu_prot(dbiu_prot), .dbiu_d(dbiu_d),
    .dbiu_stb_ack(dbiu_stb_ack), .dbiu_d_ack(dbiu_d_ack), .dbiu_ack(dbiu_ack), .dbiu_err(dbiu_err),
    .dbiu_adro(dbiu_adro), .dbiu_q(dbiu_q),
    .biu_stb(biu_stb), .biu_adri(biu_adri), .biu_size(biu_size), .biu_type(biu_type),
    .biu_we(biu_we), .biu_lock(biu_lock), .biu_prot(biu_prot), .biu_d(biu_d),
    .biu_stb_ack(biu_stb_ack), .biu_d_ack(biu_d_ack), .biu_ack(biu_ack), .biu_err(biu_err),
    .biu_adro(biu_adro), .biu_q(biu_q)
  );

  pu_riscv_biu_arbiter #(.XLEN(32), .PLEN(32), .DPRIO(0)) dut_rr (
    .HCLK(HCLK), .HRESET(HRESET),
    .ibiu_stb(ibiu_stb), .ibiu_adri(ibiu_adri), .ibiu_size(ibiu_size), .ibiu_type(ibiu_type),
    .ibiu_we(ibiu_we), .ibiu_lock(ibiu_lock), .ibiu_prot(ibiu_prot), .ibiu_d(ibiu_d),
    .ibiu_stb_ack(r_ibiu_stb_ack), .ibiu_d_ack(r_ibiu_d_ack), .ibiu_ack(r_ibiu_ack), .ibiu_err(r_ibiu_err),
    .ibiu_adro(r_ibiu_adro), .ibiu_q(r_ibiu_q),
    .dbiu_stb(dbiu_stb), .dbiu_adri(dbiu_adri), .dbiu_size(dbiu_size), .dbiu_type(dbiu_type),
    .dbiu_we(dbiu_we), .dbiu_lock(dbiu_lock), .dbiu_prot(dbiu_prot), .dbiu_d(dbiu_d),
    .dbiu_stb_ack(r_dbiu_stb_ack), .dbiu_d_ack(r_dbiu_d_ack), .dbiu_ack(r_dbiu_ack), .dbiu_err(r_dbiu_err),
    .dbiu_adro(r_dbiu_adro), .dbiu_q(r_dbiu_q),
    .biu_stb(r_biu_stb), .biu_adri(r_biu_adri), .biu_size(r_biu_size), .biu_type(r_biu_type),
    .biu_we(r_biu_we), .biu_lock(r_biu_lock), .biu_prot(r_biu_prot), .biu_d(r_biu_d),
    .biu_stb_ack(biu_stb_ack), .biu_d_ack(biu_d_ack), .biu_ack(biu_ack), .biu_err(biu_err),
    .biu_adro(biu_adro), .biu_q(biu_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Upstream handshakes: owner side gets {stb_ack,d_ack,ack,err}, other side zeros.
  task automatic chk_up(input string tag, input bit side, input bit sa, input bit da,
                        input bit ak, input bit er);
    logic [7:0] e;
    e = side ? {4'b0000, sa, da, ak, er} : {sa, da, ak, er, 4'b0000};
    check(tag, {24'b0, ibiu_stb_ack, ibiu_d_ack, ibiu_ack, ibiu_err,
                dbiu_stb_ack, dbiu_d_ack, dbiu_ack, dbiu_err}, {24'b0, e});
  endtask

  // Forwarded request must match what the bench drives on the owner side.
  task automatic chk_fwd(input string tag, input bit side);
    check({tag, "_adri"}, biu_adri, side ? dbiu_adri : ibiu_adri);
    check({tag, "_d"}, biu_d, side ? dbiu_d : ibiu_d);
    check({tag, "_ctl"}, {20'b0, biu_size, biu_type, biu_we, biu_lock, biu_prot},
          side ? {20'b0, dbiu_size, dbiu_type, dbiu_we, dbiu_lock, dbiu_prot}
               : {20'b0, ibiu_size, ibiu_type, ibiu_we, ibiu_lock, ibiu_prot});
  endtask

  task automatic drive_req(input bit side, input bit stb, input logic [2:0] typ,
                           input bit we, input bit lk);
    if (side) begin
      dbiu_stb = stb; dbiu_adri = $urandom; dbiu_size = 3'd2; dbiu_type = typ;
      dbiu_we = we; dbiu_lock = lk; dbiu_prot = 3'($urandom); dbiu_d = $urandom;
    end else begin
      ibiu_stb = stb; ibiu_adri = $urandom; ibiu_size = 3'd2; ibiu_type = typ;
      ibiu_we = we; ibiu_lock = lk; ibiu_prot = 3'($urandom); ibiu_d = $urandom;
    end
  endtask

  task automatic bus_quiet();
    biu_stb_ack = 1'b0; biu_d_ack = 1'b0; biu_ack = 1'b0; biu_err = 1'b0;
  endtask

  // One transaction from the arbitration cycle to the last (or erroring) beat.
  // err_beat < 0: no error. rr_chk: also check the DPRIO=0 instance's tie winner.
  task automatic txn(input bit side, input logic [2:0] typ, input bit we, input bit lk,
                     input int sa_wait, input bit zw, input int err_beat,
                     input bit other_stb, input bit rr_chk, input bit gaps);
    int nb, b;
    logic [31:0] side_a, other_a;
    logic [2:0] otyp;
    bit rr_side;
    nb = beats_tab[typ];
    otyp = 3'($urandom);
    @(negedge HCLK);
    bus_quiet();
    drive_req(side, 1'b1, typ, we, lk);
    drive_req(!side, other_stb, otyp, 1'b0, 1'b0);
    side_a  = side ? dbiu_adri : ibiu_adri;
    other_a = side ? ibiu_adri : dbiu_adri;
    rr_side = other_stb ? ~model_last : side;
    #1;
    check("bubble_stb", biu_stb, 1'b0);
    chk_up("bubble_up", side, 0, 0, 0, 0);
    for (int w = 0; w <= sa_wait; w++) begin
      @(negedge HCLK);
      if (w == sa_wait) begin
        biu_stb_ack = 1'b1;
        biu_d_ack   = we;
        biu_ack     = zw && (err_beat != 0);
        biu_err     = zw && (err_beat == 0);
        biu_q = $urandom; biu_adro = $urandom;
      end
      #1;
      check("addr_stb", biu_stb, 1'b1);
      chk_fwd("addr", side);
      if (w == 0 && rr_chk) begin
        check("rr_stb", r_biu_stb, 1'b1);
        check("rr_adri", r_biu_adri, (rr_side == side) ? side_a : other_a);
      end
      if (w < sa_wait) chk_up("addr_wait_up", side, 0, 0, 0, 0);
      else chk_up("addr_ack_up", side, 1, we, zw && (err_beat != 0), zw && (err_beat == 0));
    end
    model_last = side;
    b = zw ? 1 : 0;
    while (b < nb) begin
      @(negedge HCLK);
      bus_quiet();
      if (side) dbiu_stb = 1'b0; else ibiu_stb = 1'b0;
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        #1;
        check("gap_stb", biu_stb, 1'b0);
        chk_up("gap_up", side, 0, 0, 0, 0);
      end else begin
        biu_ack = (b != err_beat);
        biu_err = (b == err_beat);
        biu_q = $urandom; biu_adro = $urandom;
        #1;
        check("data_stb", biu_stb, 1'b0);
        chk_up("beat_up", side, 0, 0, b != err_beat, b == err_beat);
        check("q_bcast", side ? dbiu_q : ibiu_q, biu_q);
        check("adro_bcast", side ? ibiu_adro : dbiu_adro, biu_adro);
        if (b == err_beat) break;
        b++;
      end
    end
  endtask

  task automatic quiet();
    @(negedge HCLK);
    bus_quiet();
    ibiu_stb = 1'b0; dbiu_stb = 1'b0; ibiu_lock = 1'b0; dbiu_lock = 1'b0;
    #1;
    check("quiet_stb", biu_stb, 1'b0);
    chk_up("quiet_up", 1'b0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_ctl"}, {20'b0, biu_stb, biu_size, biu_type, biu_we, biu_lock, biu_prot}, 32'd0);
    check({tag, "_adri"}, biu_adri, 32'd0);
    check({tag, "_d"}, biu_d, 32'd0);
    chk_up({tag, "_up"}, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    int nb, eb;
    logic [2:0] typ;
    HRESET = 1'b1;
    bus_quiet(); biu_q = 32'h0; biu_adro = 32'h0;
    drive_req(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    drive_req(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (3) @(negedge HCLK);
    #1;
    chk_all_zero("reset");
    HRESET = 1'b0;

    // 1) instr SINGLE read, stb_ack at +2, ack at +3
    txn(1'b0, 3'd0, 1'b0, 1'b0, 1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    quiet();

    // 2) ties: data first (DPRIO=1); the DPRIO=0 instance follows last owner
    txn(1'b1, 3'd0, 1'b0, 1'b0, 0, 1'b0, -1, 1'b1, 1'b1, 1'b0);
    txn(1'b0, 3'd0, 1'b0, 1'b0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    quiet();
    txn(1'b1, 3'd0, 1'b1, 1'b0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    quiet();
    txn(1'b1, 3'd0, 1'b0, 1'b0, 0, 1'b0, -1, 1'b1, 1'b1, 1'b0);
    txn(1'b0, 3'd0, 1'b0, 1'b0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    quiet();

    // 3) data WRAP4 read, consecutive acks, then a stray ack
    txn(1'b1, 3'd2, 1'b0, 1'b0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    @(negedge HCLK);
    bus_quiet(); biu_ack = 1'b1; dbiu_stb = 1'b0;
    #1;
    chk_up("stray_ack", 1'b1, 0, 0, 0, 0);
    quiet();

    // 4) INCR8 write, error on beat 3, pending instr granted afterwards
    txn(1'b1, 3'd5, 1'b1, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    txn(1'b0, 3'd0, 1'b0, 1'b0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    quiet();

    // 5) zero-wait SINGLEs back to back
    txn(1'b1, 3'd0, 1'b0, 1'b0, 0, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    txn(1'b1, 3'd0, 1'b1, 1'b0, 0, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    quiet();

    // 6) locked data SINGLEs block a waiting instr request
    txn(1'b1, 3'd0, 1'b0, 1'b1, 0, 1'b0, -1, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge HCLK);
      bus_quiet(); dbiu_stb = 1'b0; ibiu_stb = 1'b1;
      #1;
      check("lock_block_stb", biu_stb, 1'b0);
      chk_up("lock_block_up", 1'b0, 0, 0, 0, 0);
    end
    txn(1'b1, 3'd0, 1'b1, 1'b1, 0, 1'b0, -1, 1'b1, 1'b0, 1'b0);
    txn(1'b0, 3'd0, 1'b0, 1'b0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    quiet();

    // randomized transactions
    for (int i = 0; i < 16; i++) begin
      typ = 3'($urandom_range(0, 7));
      nb = beats_tab[typ];
      eb = (nb > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, nb - 1)) : -1;
      txn(1'($urandom_range(0, 1)), typ, 1'($urandom_range(0, 1)), 1'b0,
          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), eb, 1'b0, 1'b0, 1'b1);
      quiet();
    end

    // reset in the middle of a data INCR4
    @(negedge HCLK);
    drive_req(1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    @(negedge HCLK);
    biu_stb_ack = 1'b1;
    #1;
    chk_up("rst_pre_sa", 1'b1, 1, 0, 0, 0);
    @(negedge HCLK);
    bus_quiet(); dbiu_stb = 1'b0; biu_ack = 1'b1;
    #1;
    chk_up("rst_pre_beat", 1'b1, 0, 0, 1, 0);
    @(negedge HCLK);
    HRESET = 1'b1;
    #1;
    chk_all_zero("rst_during");
    @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    chk_all_zero("rst_after");
    model_last = 1'b0;
    quiet();
    txn(1'b0, 3'd3, 1'b0, 1'b0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    quiet();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
